// File: rtl/lut_loader.sv
// rtl/lut_loader.sv - copies a contiguous run of constant-LUT entries into data memory
//
// Purpose: walks LUT pointers base_ptr_i .. base_ptr_i+count_i-1 and writes each
// value to data memory starting at dst_adr_i, one beat per accepted write,
// keeping an 8-bit wrap-around checksum of the values written.
//
// Ports:
//   Clk, Reset          clock (rising edge), asynchronous active-high reset
//   start_i             start request, sampled only in IDLE
//   abort_i             early termination, honoured only in WRITE
//   base_ptr_i          first LUT pointer (latched on accepted start)
//   dst_adr_i           first data-memory address (latched on accepted start)
//   count_i             number of words to copy (latched on accepted start)
//   ptr_o / lut_dat_i   LUT pointer out, combinational LUT value back
//   dm_we_o, dm_adr_o,  data-memory write request, address, data
//   dm_dat_o, dm_ready_i  and ready handshake
//   busy_o              high in WRITE and DONE
//   done_o              one-cycle completion pulse
//   sum_o               running sum of accepted words, mod 2**DATA_W
module lut_loader #(
  parameter int PTR_W  = 5,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [PTR_W-1:0]  base_ptr_i,
  input  logic [ADDR_W-1:0] dst_adr_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic [PTR_W-1:0]  ptr_o,
  input  logic [DATA_W-1:0] lut_dat_i,
  output logic              dm_we_o,
  output logic [ADDR_W-1:0] dm_adr_o,
  output logic [DATA_W-1:0] dm_dat_o,
  input  logic              dm_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] sum_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   remaining;
  logic               beat;
  logic               load;

  // LUT read is combinational, so the write data is simply the LUT output.
  assign dm_dat_o = lut_dat_i;

  always_comb begin
    state_nxt = state;
    beat      = 1'b0;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          load      = 1'b1;
          state_nxt = (count_i != '0) ? S_WRITE : S_DONE;
        end
      end
      S_WRITE: begin
        // Abort wins over a ready beat: that beat is dropped, not counted.
        if (abort_i) begin
          state_nxt = S_DONE;
        end else if (dm_ready_i) begin
          beat = 1'b1;
          if (remaining == CNT_W'(1)) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      ptr_o     <= '0;
      dm_adr_o  <= '0;
      remaining <= '0;
      sum_o     <= '0;
      dm_we_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state   <= state_nxt;
      // Status outputs are decoded from the next state so they are flops
      // that line up exactly with the state they describe.
      dm_we_o <= (state_nxt == S_WRITE);
      busy_o  <= (state_nxt != S_IDLE);
      done_o  <= (state_nxt == S_DONE);
      if (load) begin
        ptr_o     <= base_ptr_i;
        dm_adr_o  <= dst_adr_i;
        remaining <= count_i;
        sum_o     <= '0;
      end
      if (beat) begin
        sum_o     <= sum_o + lut_dat_i;
        ptr_o     <= ptr_o + PTR_W'(1);
        dm_adr_o  <= dm_adr_o + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

endmodule
